card_dealer: RTL and testbench

- Round sequencer for the bell game. Sits directly upstream of the bell-checking, press-detection and score stages.
- Each round it deals two pseudo-random cards (c1/n1, c2/n2) and opens a timed response window. While the window is open, count decays from MAX_SCORE as the available award.
- It closes the round with finish, either on a player press or on timeout. After NUM_ROUNDS rounds it ends the game.

---
 rtl/card_dealer.sv | 176 +++++++++++++++++
 tb/tb_card_dealer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//   Round sequencer for the bell game. Each round it deals two pseudo-random
//   cards, then opens a timed response window. While the window is open the
//   award value (count) decays from MAX_SCORE by one per tick and never drops
//   below 1. A bell press or a window timeout closes the round. The round then
//   stays in a fixed-length gap with finish high. After NUM_ROUNDS rounds the
//   game ends in DONE, which only reset leaves.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous, active-low reset
//   start        level; begins a game when sampled high in IDLE
//   keypad_in    raw keypad code; 4'b0111 / 4'b1001 are the two bell keys
//   c1, n1       card 1 colour / number (1..5)
//   c2, n2       card 2 colour / number (1..5)
//   count        current award value
//   round_valid  high while cards are shown and the window is open
//   finish       high in the inter-round gap and in DONE
//   round_idx    number of completed rounds
//   game_over    high in DONE
// -----------------------------------------------------------------------------
module card_dealer #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned WINDOW_TICKS = 100,
  parameter int unsigned GAP_TICKS    = 20,
  parameter int unsigned MAX_SCORE    = 100,
  parameter int unsigned NUM_ROUNDS   = 20,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] keypad_in,
  output logic [1:0] c1,
  output logic [2:0] n1,
  output logic [1:0] c2,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       round_valid,
  output logic       finish,
  output logic [7:0] round_idx,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  LP_WIN_LAST  = 8'(WINDOW_TICKS - 1);
  localparam logic [7:0]  LP_GAP_LAST  = 8'(GAP_TICKS - 1);
  localparam logic [7:0]  LP_MAX       = 8'(MAX_SCORE);
  localparam logic [7:0]  LP_ROUNDS    = 8'(NUM_ROUNDS);
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LP_POLY      = 16'hB400;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;
  logic [15:0] r_presc;
  logic [7:0]  r_ticks;
  logic [7:0]  r_count;
  logic [7:0]  r_round_idx;
  logic [1:0]  r_c1;
  logic [1:0]  r_c2;
  logic [2:0]  r_n1;
  logic [2:0]  r_n2;
  logic        w_timed;
  logic        w_press;
  logic        w_tick;
  logic        w_window_end;
  logic        w_gap_end;
  logic        w_state_change;

  // (v mod 5) + 1 for a 3-bit v: 5..7 wrap to 1..3.
  function automatic logic [2:0] card_num(input logic [2:0] v);
    return (v >= 3'd5) ? (v - 3'd4) : (v + 3'd1);
  endfunction

  assign w_lfsr_nxt     = r_lfsr[0] ? ((r_lfsr >> 1) ^ LP_POLY) : (r_lfsr >> 1);
  assign w_timed        = (r_state == S_SHOW) || (r_state == S_GAP);
  assign w_press        = (keypad_in == 4'b0111) || (keypad_in == 4'b1001);
  assign w_tick         = w_timed && (r_presc == LP_TICK_LAST);
  // The tick counter still holds the count of earlier ticks, so "last" is N-1.
  assign w_window_end   = (r_state == S_SHOW) && w_tick && (r_ticks == LP_WIN_LAST);
  assign w_gap_end      = (r_state == S_GAP) && w_tick && (r_ticks == LP_GAP_LAST);
  assign w_state_change = (w_state_nxt != r_state);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default at the top of the block keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_DEAL;
      S_DEAL: w_state_nxt = S_SHOW;
      S_SHOW: if (w_press || w_window_end) w_state_nxt = S_GAP;
      S_GAP: begin
        if (w_gap_end) w_state_nxt = (r_round_idx == LP_ROUNDS) ? S_DONE : S_DEAL;
      end
      S_DONE: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr      <= SEED;
      r_presc     <= '0;
      r_ticks     <= '0;
      r_count     <= '0;
      r_round_idx <= '0;
      r_c1        <= '0;
      r_n1        <= '0;
      r_c2        <= '0;
      r_n2        <= '0;
    end else begin
      r_lfsr <= w_lfsr_nxt;

      // Prescaler and tick counter restart on every state entry, so SHOW and
      // GAP each begin with a full tick period.
      if (w_state_change || !w_timed) begin
        r_presc <= '0;
        r_ticks <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_ticks <= r_ticks + 8'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end

      if (r_state == S_DEAL) begin
        r_c1    <= r_lfsr[1:0];
        r_n1    <= card_num(r_lfsr[4:2]);
        r_c2    <= r_lfsr[9:8];
        r_n2    <= card_num(r_lfsr[12:10]);
        r_count <= LP_MAX;
      end

      // A press beats a coincident tick: the award keeps its pre-tick value.
      if ((r_state == S_SHOW) && w_tick && !w_press && (r_count > 8'd1)) begin
        r_count <= r_count - 8'd1;
      end

      if ((r_state == S_SHOW) && (w_state_nxt == S_GAP)) begin
        r_round_idx <= r_round_idx + 8'd1;
      end
    end
  end

  assign c1          = r_c1;
  assign n1          = r_n1;
  assign c2          = r_c2;
  assign n2          = r_n2;
  assign count       = r_count;
  assign round_idx   = r_round_idx;
  assign round_valid = (r_state == S_SHOW);
  assign finish      = (r_state == S_GAP) || (r_state == S_DONE);
  assign game_over   = (r_state == S_DONE);

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
//   Directed bench for card_dealer. Two instances share every input. One uses
//   MAX_SCORE=100 to show the decay and the press/timeout priority. The other
//   uses MAX_SCORE=3 to show the award saturating at 1. Expected round results
//   go into a queue when a round's stimulus is planned. They are popped and
//   compared when finish rises.
// -----------------------------------------------------------------------------
module tb_card_dealer;

  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned WINDOW_TICKS = 5;
  localparam int unsigned GAP_TICKS    = 2;
  localparam int unsigned NUM_ROUNDS   = 2;
  localparam logic [15:0] SEED         = 16'hACE1;

  typedef struct packed {
    logic [1:0] c1;
    logic [2:0] n1;
    logic [1:0] c2;
    logic [2:0] n2;
    logic [7:0] count;
    logic [7:0] count_s;
    logic [7:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] keypad_in = 4'd0;

  logic [1:0] c1, c2, s_c1, s_c2;
  logic [2:0] n1, n2, s_n1, s_n2;
  logic [7:0] count, s_count, round_idx, s_round_idx;
  logic       round_valid, finish, game_over;
  logic       s_round_valid, s_finish, s_game_over;

  exp_t        sb[$];
  exp_t        cur;
  int          n_pass = 0;
  int          n_checks = 0;
  int          bad;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  card_dealer #(
    .TICK_DIV(TICK_DIV), .WINDOW_TICKS(WINDOW_TICKS), .GAP_TICKS(GAP_TICKS),
    .MAX_SCORE(100), .NUM_ROUNDS(NUM_ROUNDS), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .keypad_in(keypad_in),
    .c1(c1), .n1(n1), .c2(c2), .n2(n2), .count(count),
    .round_valid(round_valid), .finish(finish), .round_idx(round_idx),
    .game_over(game_over)
  );

  card_dealer #(
    .TICK_DIV(TICK_DIV), .WINDOW_TICKS(WINDOW_TICKS), .GAP_TICKS(GAP_TICKS),
    .MAX_SCORE(3), .NUM_ROUNDS(NUM_ROUNDS), .SEED(SEED)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start), .keypad_in(keypad_in),
    .c1(s_c1), .n1(s_n1), .c2(s_c2), .n2(s_n2), .count(s_count),
    .round_valid(s_round_valid), .finish(s_finish), .round_idx(s_round_idx),
    .game_over(s_game_over)
  );

  // Reference LFSR: Galois form of x^16+x^14+x^13+x^11+1.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic logic [2:0] card_num(input logic [2:0] v);
    int x;
    x = int'(v);
    return 3'((x % 5) + 1);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("%s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of a DEAL cycle; returns at the first SHOW cycle.
  task automatic deal_show(output exp_t e);
    logic [15:0] v;
    v = m_lfsr;
    e = '0;
    e.c1 = v[1:0];
    e.n1 = card_num(v[4:2]);
    e.c2 = v[9:8];
    e.n2 = card_num(v[12:10]);
    check("deal_round_valid", round_valid, 0);
    check("deal_finish", finish, 0);
    @(negedge clk);
    check("show_round_valid", round_valid, 1);
    check("show_finish", finish, 0);
    check("show_count", count, 100);
    check("show_count_sat", s_count, 3);
    check("show_c1", c1, e.c1);
    check("show_n1", n1, e.n1);
    check("show_c2", c2, e.c2);
    check("show_n2", n2, e.n2);
    check("n1_range", (n1 >= 3'd1 && n1 <= 3'd5), 1);
    check("n2_range", (n2 >= 3'd1 && n2 <= 3'd5), 1);
    check("sat_cards", {s_c1, s_n1, s_c2, s_n2}, {e.c1, e.n1, e.c2, e.n2});
    check("sat_round_valid", s_round_valid, 1);
  endtask

  // Waits (bounded) for finish, then compares the DUT against the oldest
  // expected round result.
  task automatic pop_on_finish(input int bound, input int exp_wait);
    exp_t e;
    int   w;
    w = 0;
    while (finish !== 1'b1 && w < bound) begin
      @(negedge clk);
      w++;
    end
    check("finish_seen", finish, 1);
    check("finish_latency", 16'(w), 16'(exp_wait));
    check("sb_depth", 16'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("gap_c1", c1, e.c1);
      check("gap_n1", n1, e.n1);
      check("gap_c2", c2, e.c2);
      check("gap_n2", n2, e.n2);
      check("gap_count", count, e.count);
      check("gap_count_sat", s_count, e.count_s);
      check("gap_round_idx", round_idx, e.idx);
      check("gap_round_idx_sat", s_round_idx, e.idx);
      check("gap_round_valid", round_valid, 0);
      check("gap_finish_sat", s_finish, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_c1", c1, 0);
    check("rst_n1", n1, 0);
    check("rst_c2", c2, 0);
    check("rst_n2", n2, 0);
    check("rst_count", count, 0);
    check("rst_round_valid", round_valid, 0);
    check("rst_finish", finish, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_game_over", game_over, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_round_valid", round_valid, 0);

    // Game 1, round 1: non-bell code ignored, press after 3 ticks.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    deal_show(cur);
    repeat (5) @(negedge clk);
    keypad_in = 4'b0110;
    @(negedge clk);
    keypad_in = 4'd0;
    check("nonbell_round_valid", round_valid, 1);
    check("decay_1", count, 99);
    check("decay_1_sat", s_count, 2);
    repeat (6) @(negedge clk);
    check("decay_3", count, 97);
    check("decay_3_sat", s_count, 1);
    cur.count = 8'd97; cur.count_s = 8'd1; cur.idx = 8'd1;
    sb.push_back(cur);
    keypad_in = 4'b0111;
    @(negedge clk);
    keypad_in = 4'd0;
    pop_on_finish(4, 0);

    // Game 1, round 2: timeout on the 5th tick.
    repeat (8) @(negedge clk);
    deal_show(cur);
    cur.count = 8'd95; cur.count_s = 8'd1; cur.idx = 8'd2;
    sb.push_back(cur);
    repeat (19) @(negedge clk);
    check("pre_timeout_count", count, 96);
    check("pre_timeout_finish", finish, 0);
    pop_on_finish(4, 1);

    // Game end, start ignored in DONE.
    repeat (8) @(negedge clk);
    check("done_game_over", game_over, 1);
    check("done_game_over_sat", s_game_over, 1);
    check("done_finish", finish, 1);
    check("done_round_idx", round_idx, 2);
    check("done_round_valid", round_valid, 0);
    check("done_count", count, 95);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("done_hold_game_over", game_over, 1);
    check("done_hold_round_valid", round_valid, 0);
    check("done_hold_round_idx", round_idx, 2);
    check("done_hold_count", count, 95);

    // Reset out of DONE takes effect before the next clock edge.
    rst = 1'b0;
    #1;
    check("rst_done_game_over", game_over, 0);
    check("rst_done_finish", finish, 0);
    check("rst_done_round_idx", round_idx, 0);
    check("rst_done_count", count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Game 2, round 1: press in the same cycle as the timeout tick.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    deal_show(cur);
    repeat (19) @(negedge clk);
    cur.count = 8'd96; cur.count_s = 8'd1; cur.idx = 8'd1;
    sb.push_back(cur);
    keypad_in = 4'b0111;
    @(negedge clk);
    keypad_in = 4'd0;
    pop_on_finish(4, 0);

    // Press during GAP: no effect on round_idx, count or gap length.
    repeat (2) @(negedge clk);
    keypad_in = 4'b1001;
    repeat (3) @(negedge clk);
    keypad_in = 4'd0;
    check("gap_press_round_idx", round_idx, 1);
    check("gap_press_count", count, 96);
    check("gap_press_finish", finish, 1);
    check("gap_press_round_valid", round_valid, 0);
    repeat (2) @(negedge clk);
    check("gap_len_finish", finish, 1);
    @(negedge clk);
    deal_show(cur);

    // Reset in the middle of SHOW.
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midshow_round_valid", round_valid, 0);
    check("midshow_finish", finish, 0);
    check("midshow_count", count, 0);
    check("midshow_count_sat", s_count, 0);
    check("midshow_cards", {c1, n1, c2, n2}, 0);
    check("midshow_round_idx", round_idx, 0);
    check("midshow_game_over", game_over, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({c1, n1, c2, n2, count, round_valid, finish, round_idx, game_over} != '0) bad++;
    end
    check("idle_hold_50", 16'(bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
